// File: rtl/serial_fa_sequencer_if.sv
// Request/result bus of the bit-serial add sequencer.
// The sub select exists only when SERIAL_ADD_SUB_EN is defined.
interface serial_fa_sequencer_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             cin_in;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum_out;
  logic             cout_out;

`ifdef SERIAL_ADD_SUB_EN
  modport master (
    output start, a_in, b_in, cin_in, sub,
    input  busy, done, sum_out, cout_out
  );

  modport slave (
    input  start, a_in, b_in, cin_in, sub,
    output busy, done, sum_out, cout_out
  );
`else
  modport master (
    output start, a_in, b_in, cin_in,
    input  busy, done, sum_out, cout_out
  );

  modport slave (
    input  start, a_in, b_in, cin_in,
    output busy, done, sum_out, cout_out
  );
`endif

endinterface

// File: rtl/serial_fa_sequencer.sv
// Bit-serial add controller driving an external single-bit full adder, LSB first.
// Define SERIAL_ADD_SUB_EN to add two's-complement subtraction via bus.sub.
module serial_fa_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  serial_fa_sequencer_if.slave  bus,
  output logic                  fa_a,
  output logic                  fa_b,
  output logic                  fa_cin,
  input  logic                  fa_sum,
  input  logic                  fa_cout
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_n;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  // The LSB of the result shifter would only ever fall off the bottom, so it is not stored.
  logic [WIDTH-1:1] res_sh_r;
  logic             carry_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] sum_out_r;
  logic             cout_out_r;

  logic [WIDTH-1:0] b_load_s;
  logic             carry_load_s;
  logic [WIDTH-1:0] res_next_s;
  logic             last_s;

  // Operand B / initial carry selection at the accepting edge
  always_comb begin
    b_load_s     = bus.b_in;
    carry_load_s = bus.cin_in;
`ifdef SERIAL_ADD_SUB_EN
    if (bus.sub) begin
      b_load_s     = ~bus.b_in;
      carry_load_s = 1'b1;
    end else begin
      b_load_s     = bus.b_in;
      carry_load_s = bus.cin_in;
    end
`endif
  end

  // Result shift value and final-bit detect
  always_comb begin
    res_next_s = {fa_sum, res_sh_r};
    if (cnt_r == LAST_BIT) begin
      last_s = 1'b1;
    end else begin
      last_s = 1'b0;
    end
  end

  // Next-state logic
  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_n = RUN;
        end else begin
          state_n = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_n = DONE;
        end else begin
          state_n = RUN;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State register with busy/done registered from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      busy_r  <= (state_n == RUN);
      done_r  <= (state_n == DONE);
    end
  end

  // Operand/result shifters, carry flip-flop, bit counter and held result
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh_r     <= {WIDTH{1'b0}};
      b_sh_r     <= {WIDTH{1'b0}};
      res_sh_r   <= {(WIDTH-1){1'b0}};
      carry_r    <= 1'b0;
      cnt_r      <= {CNT_W{1'b0}};
      sum_out_r  <= {WIDTH{1'b0}};
      cout_out_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            a_sh_r  <= bus.a_in;
            b_sh_r  <= b_load_s;
            carry_r <= carry_load_s;
            cnt_r   <= {CNT_W{1'b0}};
          end
        end
        RUN: begin
          res_sh_r <= res_next_s[WIDTH-1:1];
          a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
          b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
          carry_r  <= fa_cout;
          cnt_r    <= cnt_r + CNT_W'(1);
          if (last_s) begin
            sum_out_r  <= res_next_s;
            cout_out_r <= fa_cout;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // The adder path must settle within the cycle, so the bit pair comes straight from registers.
  assign fa_a   = (state_r == RUN) & a_sh_r[0];
  assign fa_b   = (state_r == RUN) & b_sh_r[0];
  assign fa_cin = (state_r == RUN) & carry_r;

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.sum_out  = sum_out_r;
  assign bus.cout_out = cout_out_r;

endmodule

// File: tb/tb_serial_fa_sequencer.sv
// Scoreboard bench for serial_fa_sequencer with a behavioural full adder cell.
// Define SERIAL_ADD_SUB_EN to also exercise subtraction.
module tb_serial_fa_sequencer;

  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fa_a, fa_b, fa_cin, fa_sum, fa_cout;

  always #5 clk = ~clk;

  serial_fa_sequencer_if #(.WIDTH(WIDTH)) bus ();

  serial_fa_sequencer #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .fa_a    (fa_a),
    .fa_b    (fa_b),
    .fa_cin  (fa_cin),
    .fa_sum  (fa_sum),
    .fa_cout (fa_cout)
  );

  assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
  assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [WIDTH:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on each done and checks pulse shape and result hold
  int busy_cnt = 0;
  logic prev_done = 1'b0;
  logic held_valid = 1'b0;
  logic [WIDTH:0] held = '0;

  always @(negedge clk) begin
    if (rst) begin
      busy_cnt = 0;
      held_valid = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        chk("done_width", 32'(prev_done), 32'd0);
        chk("busy_len", 32'(busy_cnt), 32'(WIDTH));
        chk("busy_in_done", 32'(bus.busy), 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got result 0x%0h expected no done (t=%0t)",
                   {bus.cout_out, bus.sum_out}, $time);
          held_valid = 1'b0;
        end else begin
          held = exp_q.pop_front();
          chk("result", 32'({bus.cout_out, bus.sum_out}), 32'(held));
          held_valid = 1'b1;
        end
        busy_cnt = 0;
      end else if (held_valid) begin
        chk("hold", 32'({bus.cout_out, bus.sum_out}), 32'(held));
      end
      prev_done = bus.done;
    end
  end

  // One transaction; with hammer set, start stays high (with other operands) until done
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin, input logic [WIDTH:0] exp, input bit hammer);
    int n;
    bit got;
    exp_q.push_back(exp);
    bus.a_in   = a;
    bus.b_in   = b;
    bus.cin_in = cin;
    bus.start  = 1'b1;
    @(posedge clk);
    #1;
    if (hammer) begin
      bus.a_in   = 8'h01;
      bus.b_in   = 8'h01;
      bus.cin_in = 1'b0;
    end else begin
      bus.start = 1'b0;
    end
    n = 0;
    got = 1'b0;
    while (n < 30 && !got) begin
      @(negedge clk);
      n++;
      if (bus.done) got = 1'b1;
    end
    bus.start = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done in %0d cycles expected done at %0d", n, WIDTH + 1);
    end else begin
      chk("done_latency", 32'(n), 32'(WIDTH + 1));
    end
    @(posedge clk);
    #1;
    chk("idle_after", 32'({bus.busy, bus.done}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish before 200000");
    $fatal(1, "watchdog");
  end

  logic [WIDTH-1:0] bb_a[3];
  logic [WIDTH-1:0] bb_b[3];
  logic             bb_c[3];
  logic [WIDTH:0]   bb_e[3];

  initial begin
    int done_cyc[3];
    int n;
    bit got;
    bus.start  = 1'b0;
    bus.a_in   = '0;
    bus.b_in   = '0;
    bus.cin_in = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    bus.sub    = 1'b0;
`endif
    bb_a = '{8'h12, 8'h80, 8'hC3};
    bb_b = '{8'h34, 8'h80, 8'h3C};
    bb_c = '{1'b1, 1'b0, 1'b0};
    bb_e = '{9'h047, 9'h100, 9'h0FF};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_sum", 32'(bus.sum_out), 32'd0);
    chk("rst_cout", 32'(bus.cout_out), 32'd0);
    chk("rst_fa", 32'({fa_a, fa_b, fa_cin}), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_op(8'h5A, 8'h3C, 1'b0, 9'h096, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 9'h100, 1'b0);
    run_op(8'hFF, 8'h00, 1'b1, 9'h100, 1'b0);
    run_op(8'h5A, 8'h3C, 1'b0, 9'h096, 1'b1);

    // Reset in the 4th RUN cycle discards the operation
    bus.a_in   = 8'h11;
    bus.b_in   = 8'h22;
    bus.cin_in = 1'b0;
    bus.start  = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("busy_before_rst", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    chk("midrst_sum", 32'(bus.sum_out), 32'd0);
    chk("midrst_cout", 32'(bus.cout_out), 32'd0);
    chk("midrst_fa", 32'({fa_a, fa_b, fa_cin}), 32'd0);
    repeat (12) @(negedge clk);
    chk("midrst_idle", 32'({bus.busy, bus.done}), 32'd0);
    @(posedge clk);
    #1;
    run_op(8'h33, 8'h44, 1'b1, 9'h078, 1'b0);

    // Back-to-back with start held high
    for (int i = 0; i < 3; i++) exp_q.push_back(bb_e[i]);
    bus.a_in   = bb_a[0];
    bus.b_in   = bb_b[0];
    bus.cin_in = bb_c[0];
    bus.start  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n = 0;
      got = 1'b0;
      while (n < 30 && !got) begin
        @(negedge clk);
        n++;
        if (bus.done) got = 1'b1;
      end
      done_cyc[i] = cyc;
      if (!got) begin
        checks++;
        errors++;
        $display("FAIL b2b_timeout: got no done for op %0d expected done within 30 cycles", i);
      end
      if (i < 2) begin
        bus.a_in   = bb_a[i+1];
        bus.b_in   = bb_b[i+1];
        bus.cin_in = bb_c[i+1];
      end else begin
        bus.start = 1'b0;
      end
    end
    chk("b2b_period1", 32'(done_cyc[1] - done_cyc[0]), 32'(WIDTH + 2));
    chk("b2b_period2", 32'(done_cyc[2] - done_cyc[1]), 32'(WIDTH + 2));
    repeat (4) @(negedge clk);
    chk("b2b_idle", 32'({bus.busy, bus.done}), 32'd0);
    @(posedge clk);
    #1;

`ifdef SERIAL_ADD_SUB_EN
    bus.sub = 1'b1;
    run_op(8'h10, 8'h01, 1'b0, 9'h10F, 1'b0);
    run_op(8'h01, 8'h02, 1'b1, 9'h0FF, 1'b0);
    bus.sub = 1'b0;
    run_op(8'h01, 8'h02, 1'b1, 9'h004, 1'b0);
`endif

    repeat (3) @(posedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
